// File: rtl/dac_serializer.sv
// dac_serializer: latches one 24-bit filtered sample per frame and shifts it out
// as mono I2S (same sample on left and right), MSB first with a one-slot delay.
module dac_serializer #(
    parameter int unsigned BCLK_DIV   = 4,
    parameter int unsigned FRAME_BITS = 32
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [23:0] WaveIn,
    output logic        SampleReq,
    output logic        BClk,
    output logic        LRClk,
    output logic        SData
);

    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned SLOTS    = 2 * FRAME_BITS;
    localparam int unsigned HALF_DIV = BCLK_DIV / 2;
    localparam int unsigned DIV_W    = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned SLOT_W   = $clog2(SLOTS);
    localparam int unsigned IDX_W    = $clog2(SAMPLE_W);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateT;

    stateT                state;
    logic [DIV_W-1:0]     divCnt;
    logic [SLOT_W-1:0]    slotCnt;
    logic [SAMPLE_W-1:0]  shadow;

    logic                 divLast;
    logic                 frameLast;
    logic [DIV_W-1:0]     nextDiv;
    logic [SLOT_W-1:0]    nextSlot;
    logic [SLOT_W-1:0]    chanSlot;
    logic                 nextLR;
    logic                 slotBit;

    // Next divider/slot position and the serial bit belonging to the upcoming slot
    always_comb begin
        divLast   = 1'b0;
        frameLast = 1'b0;
        nextDiv   = '0;
        nextSlot  = slotCnt;
        chanSlot  = '0;
        nextLR    = 1'b0;
        slotBit   = 1'b0;

        divLast   = (divCnt == DIV_W'(BCLK_DIV - 1));
        frameLast = divLast && (slotCnt == SLOT_W'(SLOTS - 1));
        nextDiv   = divLast ? '0 : divCnt + DIV_W'(1);

        if (frameLast) begin
            nextSlot = '0;
        end else if (divLast) begin
            nextSlot = slotCnt + SLOT_W'(1);
        end

        nextLR   = (nextSlot >= SLOT_W'(FRAME_BITS));
        chanSlot = nextLR ? nextSlot - SLOT_W'(FRAME_BITS) : nextSlot;

        // Channel slot k carries shadow[24-k] for k = 1..24; slot 0 and the tail are zero pad
        if ((chanSlot >= SLOT_W'(1)) && (chanSlot <= SLOT_W'(SAMPLE_W))) begin
            slotBit = shadow[IDX_W'(SLOT_W'(SAMPLE_W) - chanSlot)];
        end
    end

    // Framing state machine with registered serial outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            divCnt    <= '0;
            slotCnt   <= '0;
            shadow    <= '0;
            SampleReq <= 1'b0;
            BClk      <= 1'b0;
            LRClk     <= 1'b0;
            SData     <= 1'b0;
        end else begin
            SampleReq <= 1'b0;
            case (state)
                IDLE: begin
                    divCnt  <= '0;
                    slotCnt <= '0;
                    BClk    <= 1'b0;
                    LRClk   <= 1'b0;
                    SData   <= 1'b0;
                    if (Enable) begin
                        // Start slot 0 immediately with a fresh sample
                        state     <= RUN;
                        shadow    <= WaveIn;
                        SampleReq <= 1'b1;
                    end
                end

                RUN: begin
                    if (frameLast && !Enable) begin
                        // Frame completed with no run request: park instead of wrapping
                        state   <= IDLE;
                        divCnt  <= '0;
                        slotCnt <= '0;
                        BClk    <= 1'b0;
                        LRClk   <= 1'b0;
                        SData   <= 1'b0;
                    end else begin
                        divCnt  <= nextDiv;
                        slotCnt <= nextSlot;
                        BClk    <= (nextDiv >= DIV_W'(HALF_DIV));
                        if (divLast) begin
                            LRClk <= nextLR;
                            SData <= slotBit;
                        end
                        if (frameLast) begin
                            shadow    <= WaveIn;
                            SampleReq <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
